// File: rtl/four_to_two_encoder_pkg.sv
// four_to_two_encoder_pkg
//   Shared definitions for the 4-to-2 priority encoder and its 2-to-4
//   decoder counterpart: FSM state encoding, the 2-bit code constants and
//   small helpers (code -> one-hot, population count).
package four_to_two_encoder_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [1:0] CODE_Y0 = 2'd0;
  localparam logic [1:0] CODE_Y1 = 2'd1;
  localparam logic [1:0] CODE_Y2 = 2'd2;
  localparam logic [1:0] CODE_Y3 = 2'd3;

  // One-hot mask for a 2-bit code; the same mapping the decoder implements.
  function automatic logic [3:0] onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 4; i++) c = c + 3'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/four_to_two_encoder_pe.sv
// priority_encode4
//   Combinational 4-input priority encoder; the highest set index wins.
//   Ports:
//     req  in   4  request vector
//     code out  2  index of highest set bit (CODE_Y0 when none set)
//     any  out  1  at least one bit of req is set
module priority_encode4
  import four_to_two_encoder_pkg::*;
(
  input  logic [3:0] req,
  output logic [1:0] code,
  output logic       any
);

  always_comb begin
    any  = |req;
    code = CODE_Y0;
    if (req[3])      code = CODE_Y3;
    else if (req[2]) code = CODE_Y2;
    else if (req[1]) code = CODE_Y1;
    else             code = CODE_Y0;
  end

endmodule

// File: rtl/four_to_two_encoder.sv
// four_to_two_encoder
//   Registered, handshaked 4-to-2 priority encoder. Rising edges on Y3..Y0
//   set sticky pending bits; the highest pending index is presented on
//   A1,A0 with valid and held until ack.
//   Ports:
//     clk         in   1  clock, rising edge
//     reset       in   1  asynchronous, active-high
//     enable      in   1  capture new request edges when 1
//     Y3..Y0      in   1  level request lines, Y3 highest priority
//     ack         in   1  consumer accepts the presented code (while valid)
//     A1, A0      out  1  presented code, A1 is MSB
//     valid       out  1  A1,A0 hold a pending unacknowledged request
//     pend_count  out  3  number of pending bits, including the presented one
//     overrun     out  1  sticky: edge arrived on an already-pending bit
module four_to_two_encoder
  import four_to_two_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       Y3,
  input  logic       Y2,
  input  logic       Y1,
  input  logic       Y0,
  input  logic       ack,
  output logic       A1,
  output logic       A0,
  output logic       valid,
  output logic [2:0] pend_count,
  output logic       overrun
);

  logic [3:0] y, y_d, pend, rise, clr, pend_next;
  logic [1:0] code, nxt_code;
  logic       nxt_any, ovr_hit;
  // Low for the first edge after reset: lines already high when reset is
  // released are taken as levels, not edges, so nothing is captured for them.
  logic       armed;
  state_t     state;

  assign y = {Y3, Y2, Y1, Y0};

  always_comb begin
    rise      = (armed && enable) ? (y & ~y_d) : 4'b0000;
    clr       = (valid && ack) ? onehot(code) : 4'b0000;
    // Set wins over clear on the same bit.
    pend_next = (pend & ~clr) | rise;
    ovr_hit   = |(rise & pend & ~clr);
  end

  // Shared by the IDLE load and the PRESENT back-to-back reload.
  priority_encode4 u_pe (
    .req  (pend_next),
    .code (nxt_code),
    .any  (nxt_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_d        <= 4'b0000;
      armed      <= 1'b0;
      pend       <= 4'b0000;
      pend_count <= 3'd0;
      overrun    <= 1'b0;
      code       <= CODE_Y0;
      valid      <= 1'b0;
      state      <= IDLE;
    end else begin
      y_d        <= y;
      armed      <= 1'b1;
      pend       <= pend_next;
      pend_count <= popcount4(pend_next);
      if (ovr_hit) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (nxt_any) begin
            code  <= nxt_code;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          // Without ack the presented code is frozen, even if a
          // higher-priority request has since arrived.
          if (ack) begin
            if (nxt_any) begin
              code <= nxt_code;
            end else begin
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign A1 = code[1];
  assign A0 = code[0];

endmodule

// File: tb/tb_four_to_two_encoder.sv
module tb_four_to_two_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       Y3, Y2, Y1, Y0;
  logic       ack;
  logic       A1, A0, valid, overrun;
  logic [2:0] pend_count;

  int checks   = 0;
  int failures = 0;

  // Reference state: pending requests as a bit array, the presented index.
  bit m_pend [4];
  bit m_prev [4];
  int m_code;
  bit m_valid;
  bit m_over;
  bit m_first;   // first sampled edge after reset: levels are not events

  four_to_two_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .Y3         (Y3),
    .Y2         (Y2),
    .Y1         (Y1),
    .Y0         (Y0),
    .ack        (ack),
    .A1         (A1),
    .A0         (A0),
    .valid      (valid),
    .pend_count (pend_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0;
      m_prev[i] = 0;
    end
    m_code  = 0;
    m_valid = 0;
    m_over  = 0;
    m_first = 1;
  endfunction

  function automatic void model_step(input bit [3:0] yv, input bit en, input bit ak);
    bit taken;
    taken = m_valid && ak;
    for (int i = 0; i < 4; i++) begin
      bit r;
      r = !m_first && en && yv[i] && !m_prev[i];
      if (r && m_pend[i] && !(taken && i == m_code)) m_over = 1;
      if (taken && i == m_code) m_pend[i] = 0;
      if (r) m_pend[i] = 1;
    end
    if (!m_valid || ak) begin
      m_valid = 0;
      for (int i = 0; i < 4; i++)
        if (m_pend[i]) begin
          m_valid = 1;
          m_code  = i;   // ascending scan: last hit is the highest index
        end
    end
    for (int i = 0; i < 4; i++) m_prev[i] = yv[i];
    m_first = 0;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic int dut_code();
    return int'({A1, A0});
  endfunction

  // Called at a negedge: drive inputs, take one edge, compare at the next negedge.
  task automatic step(input bit [3:0] yv, input bit en, input bit ak, input string tag);
    {Y3, Y2, Y1, Y0} = yv;
    enable = en;
    ack    = ak;
    @(posedge clk);
    model_step(yv, en, ak);
    @(negedge clk);
    chk({tag, ".valid"}, int'(valid), int'(m_valid));
    chk({tag, ".cnt"}, int'(pend_count), model_count());
    chk({tag, ".ovr"}, int'(overrun), int'(m_over));
    if (m_valid) chk({tag, ".code"}, dut_code(), m_code);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    ack = 1'b0;
    {Y3, Y2, Y1, Y0} = 4'b1111;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.code", dut_code(), 0);
    chk("rst.valid", int'(valid), 0);
    chk("rst.cnt", int'(pend_count), 0);
    chk("rst.ovr", int'(overrun), 0);
    reset = 1'b0;
    step(4'b1111, 1, 0, "rel0");
    step(4'b1111, 1, 0, "rel1");
    chk("rel.nocap", int'(valid), 0);

    // single request
    step(4'b0000, 1, 0, "s0");
    step(4'b0010, 1, 0, "s1");
    chk("single.code", dut_code(), 1);
    chk("single.cnt", int'(pend_count), 1);
    step(4'b0000, 1, 1, "s2");
    chk("single.idle", int'(valid), 0);

    // priority hold
    step(4'b0001, 1, 0, "p0");
    step(4'b1001, 1, 0, "p1");
    chk("hold.code", dut_code(), 0);
    step(4'b1001, 1, 1, "p2");
    chk("hold.next", dut_code(), 3);
    chk("hold.vld", int'(valid), 1);
    step(4'b1001, 1, 1, "p3");
    chk("hold.idle", int'(valid), 0);
    step(4'b0000, 1, 0, "p4");

    // simultaneous
    step(4'b0110, 1, 0, "m0");
    chk("simul.code", dut_code(), 2);
    chk("simul.cnt", int'(pend_count), 2);
    step(4'b0110, 1, 1, "m1");
    chk("simul.code2", dut_code(), 1);
    step(4'b0000, 1, 1, "m2");

    // enable and overrun
    step(4'b1000, 0, 0, "e0");
    chk("en.nocap", int'(valid), 0);
    step(4'b0000, 1, 0, "e1");
    step(4'b0100, 1, 0, "o0");
    step(4'b0000, 1, 0, "o1");
    step(4'b0100, 1, 0, "o2");
    chk("ovr.set", int'(overrun), 1);
    chk("ovr.cnt", int'(pend_count), 1);
    step(4'b0000, 1, 0, "o3");
    step(4'b0100, 1, 1, "o4");
    chk("ovr.repend", dut_code(), 2);
    chk("ovr.vld", int'(valid), 1);

    // asynchronous reset mid-handshake
    step(4'b0000, 1, 1, "r0");
    step(4'b1011, 1, 0, "r1");
    chk("mid.cnt", int'(pend_count), 3);
    #2 reset = 1'b1;
    #1;
    chk("async.code", dut_code(), 0);
    chk("async.valid", int'(valid), 0);
    chk("async.cnt", int'(pend_count), 0);
    chk("async.ovr", int'(overrun), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit [3:0] yv;
      yv = 4'($urandom);
      step(yv, ($urandom_range(3) != 0), 1'($urandom), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
